// File: rtl/pa_spsram_init_wrap.sv
// -----------------------------------------------------------------------------
// pa_spsram_init_wrap
//
// Purpose
//   Parametrised single-port SRAM wrapper for IFU/LSU cache and tag arrays.
//   It contains a behavioural array, a per-group write mask and a hardware
//   init engine that fills every entry with INIT_VALUE after reset (when
//   INIT_ON_RESET=1) or whenever init_req is pulsed while idle. The macro-style
//   interface (CEN/GWEN/WEN, all active low) matches the fixed-geometry
//   wrappers this block replaces.
//
// Ports
//   forever_cpuclk  in   1           clock, rising edge
//   cpurst_b        in   1           asynchronous reset, active low
//   A               in   ADDR_WIDTH  access address
//   CEN             in   1           chip enable, active low
//   GWEN            in   1           global write enable, active low (0=write, 1=read)
//   WEN             in   WE_WIDTH    per-group write enable, active low
//   D               in   DATA_WIDTH  write data
//   Q               out  DATA_WIDTH  read data
//   init_req        in   1           pulse: start re-initialisation (ignored while busy)
//   init_busy       out  1           init engine running; external accesses dropped
//   init_done       out  1           one-cycle pulse in the cycle the last init write issues
//   dbg_state_o     out  1           current engine state (0=IDLE, 1=INIT)
//
// Configuration
//   PA_SPSRAM_OUT_FLOP_EN  when defined, adds an output register after the
//                          array read: read latency becomes 2 and the extra
//                          stage only captures when a read was issued on the
//                          previous cycle. When undefined, read latency is 1.
//
// Access contract
//   An access is presented by holding CEN low for one cycle with A/GWEN/WEN/D
//   valid at the rising edge. There is no back-pressure: while init_busy is
//   high any access is silently discarded (array untouched, Q holds), so the
//   requester must gate its accesses on init_busy. A read returns mem[A] on Q
//   after the read latency and Q then holds until the next read. Writes never
//   change Q (no write-through). A/D/WEN are don't-care while CEN is high.
// -----------------------------------------------------------------------------
module pa_spsram_init_wrap #(
  parameter int unsigned           ADDR_WIDTH    = 9,
  parameter int unsigned           DATA_WIDTH    = 39,
  parameter int unsigned           WE_WIDTH      = 39,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter bit                    INIT_ON_RESET = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  init_done,
  output logic [0:0]            dbg_state_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned GRP_W = DATA_WIDTH / WE_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_INIT = 1'b1;
  localparam logic [0:0] ST_RST  = INIT_ON_RESET ? ST_INIT : ST_IDLE;

  // ---------------------------------------------------------------------------
  // Engine state
  // ---------------------------------------------------------------------------
  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic [ADDR_WIDTH-1:0] init_addr_d;
  logic                  init_done_q;
  logic                  init_done_d;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d     = ST_INIT;
          init_addr_d = '0;
        end
      end
      ST_INIT: begin
        // init_req is deliberately not looked at here: no restart mid-fill.
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        init_addr_d = '0;
      end
    endcase
  end

  // init_done is registered: it is high exactly while the engine sits on the
  // last address, i.e. the cycle in which the final fill write is issued.
  always_comb begin
    init_done_d = (state_d == ST_INIT) && (init_addr_d == LAST_ADDR);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_RST;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_busy   = (state_q == ST_INIT);
  assign init_done   = init_done_q;
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Array port arbitration: the engine owns the array whenever it is running.
  // ---------------------------------------------------------------------------
  logic                  ext_rd;
  logic                  ext_wr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [WE_WIDTH-1:0]   mem_wen_n;

  always_comb begin
    ext_rd = (state_q == ST_IDLE) && !CEN &&  GWEN;
    ext_wr = (state_q == ST_IDLE) && !CEN && !GWEN;
  end

  always_comb begin
    mem_we    = ext_wr;
    mem_addr  = A;
    mem_wdata = D;
    mem_wen_n = WEN;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = init_addr_q;
      mem_wdata = INIT_VALUE;
      mem_wen_n = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural array. Contents are not reset; the init engine clears them.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge forever_cpuclk) begin
    if (mem_we) begin
      for (int g = 0; g < int'(WE_WIDTH); g++) begin
        if (!mem_wen_n[g]) begin
          mem_q[mem_addr][g*GRP_W +: GRP_W] <= mem_wdata[g*GRP_W +: GRP_W];
        end
      end
    end
  end

  // First read stage: captures only on a served read, otherwise holds.
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_data_q <= '0;
    end else if (ext_rd) begin
      rd_data_q <= mem_q[A];
    end
  end

`ifdef PA_SPSRAM_OUT_FLOP_EN
  // Output stage: follows rd_data_q one cycle later, but only for a cycle
  // that actually carried a read, so Q still holds between reads.
  logic                  rd_issued_q;
  logic [DATA_WIDTH-1:0] q_out_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_issued_q <= 1'b0;
      q_out_q     <= '0;
    end else begin
      rd_issued_q <= ext_rd;
      if (rd_issued_q) begin
        q_out_q <= rd_data_q;
      end
    end
  end

  assign Q = q_out_q;
`else
  assign Q = rd_data_q;
`endif

endmodule
